setup_aie_hls_deadlock_reporter: RTL and testbench



---
 rtl/setup_aie_dbg_pkg.sv | 26 ++
 rtl/setup_aie_dbg_prio_enc.sv | 17 +
 rtl/setup_aie_hls_deadlock_reporter.sv | 135 +++++++++++++
 tb/tb_setup_aie_hls_deadlock_reporter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/setup_aie_dbg_pkg.sv
// Shared definitions for the setup_aie debug/trace blocks: the deadlock
// reporter FSM states, the widths of the report record fields and a
// lowest-set-bit helper.
package setup_aie_dbg_pkg;

   localparam int unsigned MON_ID_W = 4;
   localparam int unsigned MAX_MON  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_REPORT = 2'd2,
      ST_HOLD   = 2'd3
   } dbg_state_e;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [MON_ID_W-1:0] lowest_set(input logic [MAX_MON-1:0] vec);
      logic [MON_ID_W-1:0] idx;
      idx = '0;
      for (int i = int'(MAX_MON) - 1; i >= 0; i--) begin
         if (vec[i]) idx = MON_ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/setup_aie_dbg_prio_enc.sv
// Lowest-set-bit encoder for the monitor block vector.
//   vec    in  NUM_MON   one bit per monitor
//   idx_c  out MON_ID_W  index of the lowest set bit (combinational)
module setup_aie_dbg_prio_enc
   import setup_aie_dbg_pkg::*;
#(
   parameter int unsigned NUM_MON = 4
) (
   input  logic [NUM_MON-1:0]  vec,
   output logic [MON_ID_W-1:0] idx_c
);

   always_comb begin
      idx_c = lowest_set(MAX_MON'(vec));
   end

endmodule

// File: rtl/setup_aie_hls_deadlock_reporter.sv
// Debounces the HLS deadlock monitors' block outputs against a programmable
// persistence threshold, captures one report record per deadlock and hands it
// to the debug/trace path over a valid/ready handshake.
//   clock, reset      clock and synchronous active-high reset
//   block_in          block outputs of the deadlock monitors
//   axis_snapshot     live AXIS block signals, sampled at capture
//   threshold         consecutive blocked cycles needed (0 behaves as 1)
//   clear             releases HOLD and drops deadlock_sticky
//   report_valid/ready  record handshake
//   report_mon_id/snapshot/cycle  record fields, stable while valid
//   deadlock_sticky   set at capture, cleared by clear or reset
module setup_aie_hls_deadlock_reporter
   import setup_aie_dbg_pkg::*;
#(
   parameter int unsigned NUM_MON = 4,
   parameter int unsigned SNAP_W  = 2,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned CYC_W   = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_MON-1:0]  block_in,
   input  logic [SNAP_W-1:0]   axis_snapshot,
   input  logic [CNT_W-1:0]    threshold,
   input  logic                clear,
   output logic                report_valid,
   input  logic                report_ready,
   output logic [MON_ID_W-1:0] report_mon_id,
   output logic [SNAP_W-1:0]   report_snapshot,
   output logic [CYC_W-1:0]    report_cycle,
   output logic                deadlock_sticky
);

   dbg_state_e          state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [CNT_W-1:0]    thr_q, thr_d;
   logic [CYC_W-1:0]    cyc;
   logic                sticky_d;
   logic                capture;
   logic                any_block;
   logic [CNT_W-1:0]    thr_eff;
   logic [MON_ID_W-1:0] low_idx;

   assign any_block = |block_in;
   assign thr_eff   = (threshold == '0) ? CNT_W'(1) : threshold;

   setup_aie_dbg_prio_enc #(
      .NUM_MON (NUM_MON)
   ) u_prio_enc (
      .vec   (block_in),
      .idx_c (low_idx)
   );

   // State, counters and the registered record.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         thr_q           <= '0;
         cyc             <= '0;
         report_valid    <= 1'b0;
         deadlock_sticky <= 1'b0;
         report_mon_id   <= '0;
         report_snapshot <= '0;
         report_cycle    <= '0;
      end else begin
         state           <= state_d;
         cnt             <= cnt_d;
         thr_q           <= thr_d;
         cyc             <= cyc + CYC_W'(1);
         report_valid    <= (state_d == ST_REPORT);
         deadlock_sticky <= sticky_d;
         if (capture) begin
            report_mon_id   <= low_idx;
            report_snapshot <= axis_snapshot;
            report_cycle    <= cyc;
         end
      end
   end

   // Next-state logic. A threshold of one captures straight from IDLE so the
   // first blocked cycle is already the deadlock cycle.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      thr_d    = thr_q;
      sticky_d = deadlock_sticky;
      capture  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (clear) begin
               cnt_d    = '0;
               sticky_d = 1'b0;
            end else if (any_block) begin
               thr_d = thr_eff;
               if (thr_eff == CNT_W'(1)) begin
                  capture = 1'b1;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (clear || !any_block) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (clear) sticky_d = 1'b0;
            end else if (cnt == thr_q - CNT_W'(1)) begin
               capture = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_REPORT: begin
            // clear is held off until the record has been taken
            if (report_ready) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (clear) begin
               sticky_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (capture) begin
         state_d  = ST_REPORT;
         sticky_d = 1'b1;
         cnt_d    = thr_d;
      end
   end

endmodule

// File: tb/tb_setup_aie_hls_deadlock_reporter.sv
// Self-checking bench for setup_aie_hls_deadlock_reporter: directed test-plan
// scenarios followed by randomized traffic, all checked against a streak-based
// behavioural model of the reporter.
module tb_setup_aie_hls_deadlock_reporter;

   logic        clock;
   logic        reset;
   logic [3:0]  block_in;
   logic [1:0]  axis_snapshot;
   logic [15:0] threshold;
   logic        clear;
   logic        report_valid;
   logic        report_ready;
   logic [3:0]  report_mon_id;
   logic [1:0]  report_snapshot;
   logic [31:0] report_cycle;
   logic        deadlock_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   logic        m_valid, m_held, m_sticky;
   logic [3:0]  m_mon;
   logic [1:0]  m_snap;
   logic [31:0] m_rec_cyc, m_cyc;
   int          m_streak, m_thr;

   setup_aie_hls_deadlock_reporter dut (
      .clock           (clock),
      .reset           (reset),
      .block_in        (block_in),
      .axis_snapshot   (axis_snapshot),
      .threshold       (threshold),
      .clear           (clear),
      .report_valid    (report_valid),
      .report_ready    (report_ready),
      .report_mon_id   (report_mon_id),
      .report_snapshot (report_snapshot),
      .report_cycle    (report_cycle),
      .deadlock_sticky (deadlock_sticky)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the reporter described as "a streak of blocked cycles that
   // reaches the latched threshold produces one record".
   task automatic model_step(input logic [3:0] blk, input logic [15:0] thr,
                             input logic clr, input logic rdy, input logic rst,
                             input logic [1:0] snap);
      if (rst) begin
         m_valid = 0; m_held = 0; m_sticky = 0; m_mon = 0; m_snap = 0;
         m_rec_cyc = 0; m_cyc = 0; m_streak = 0; m_thr = 1;
      end else begin
         if (m_valid) begin
            if (rdy) begin
               m_valid = 0;
               m_held  = 1;
            end
         end else if (m_held) begin
            if (clr) begin
               m_held = 0; m_sticky = 0; m_streak = 0;
            end
         end else if (clr) begin
            m_streak = 0;
            m_sticky = 0;
         end else if (blk != 0) begin
            if (m_streak == 0) m_thr = (thr == 0) ? 1 : int'(thr);
            m_streak++;
            if (m_streak >= m_thr) begin
               m_mon = 0;
               for (int i = 3; i >= 0; i--) if (blk[i]) m_mon = 4'(i);
               m_snap    = snap;
               m_rec_cyc = m_cyc;
               m_valid   = 1;
               m_sticky  = 1;
               m_streak  = 0;
            end
         end else begin
            m_streak = 0;
         end
         m_cyc = m_cyc + 1;
      end
   endtask

   task automatic compare_all();
      check("valid",  64'(report_valid),    64'(m_valid));
      check("sticky", 64'(deadlock_sticky), 64'(m_sticky));
      check("mon_id", 64'(report_mon_id),   64'(m_mon));
      check("snap",   64'(report_snapshot), 64'(m_snap));
      check("cycle",  64'(report_cycle),    64'(m_rec_cyc));
   endtask

   task automatic tick(input logic [3:0] blk, input logic [15:0] thr,
                       input logic clr, input logic rdy, input logic rst);
      logic [1:0] snap;
      @(negedge clock);
      snap          = 2'($urandom);
      block_in      = blk;
      threshold     = thr;
      clear         = clr;
      report_ready  = rdy;
      reset         = rst;
      axis_snapshot = snap;
      @(posedge clock);
      model_step(blk, thr, clr, rdy, rst, snap);
      #1 compare_all();
   endtask

   initial begin
      logic [3:0]  rblk;
      logic [3:0]  s_mon;
      logic [1:0]  s_snap;
      logic [31:0] s_cyc;
      logic [31:0] c0;

      reset = 1'b1; block_in = '0; axis_snapshot = '0; threshold = '0;
      clear = 1'b0; report_ready = 1'b0;
      m_valid = 0; m_held = 0; m_sticky = 0; m_mon = 0; m_snap = 0;
      m_rec_cyc = 0; m_cyc = 0; m_streak = 0; m_thr = 1;

      tick(4'h0, 16'd0, 0, 0, 1);
      tick(4'h0, 16'd0, 0, 0, 1);
      check("reset_valid",  64'(report_valid),    64'(0));
      check("reset_sticky", 64'(deadlock_sticky), 64'(0));
      check("reset_cycle",  64'(report_cycle),    64'(0));

      // threshold 5, monitor 2 blocked from cycle 20
      while (m_cyc != 32'd20) tick(4'h0, 16'd5, 0, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         tick(4'b0100, 16'd5, 0, 0, 0);
         if (i == 4) check("tp1_early", 64'(report_valid), 64'(0));
         if (i == 5) begin
            check("tp1_valid",  64'(report_valid),    64'(1));
            check("tp1_mon",    64'(report_mon_id),   64'(2));
            check("tp1_cycle",  64'(report_cycle),    64'(24));
            check("tp1_sticky", 64'(deadlock_sticky), 64'(1));
         end
      end
      tick(4'h0, 16'd5, 0, 1, 0);
      tick(4'h0, 16'd5, 0, 0, 0);
      check("tp1_drop", 64'(report_valid), 64'(0));
      tick(4'h0, 16'd5, 1, 0, 0);
      check("tp1_clear", 64'(deadlock_sticky), 64'(0));

      // 4-cycle pulse under threshold 5 must not report
      for (int i = 0; i < 4; i++) tick(4'b0010, 16'd5, 0, 0, 0);
      for (int i = 0; i < 6; i++) tick(4'h0, 16'd5, 0, 0, 0);
      check("tp2_none", 64'(report_valid), 64'(0));
      // a fresh 5-cycle streak still needs the full threshold
      for (int i = 1; i <= 5; i++) begin
         tick(4'b0001, 16'd5, 0, 0, 0);
         if (i == 4) check("tp2_restart", 64'(report_valid), 64'(0));
      end
      check("tp2_fire", 64'(report_valid), 64'(1));
      tick(4'h0, 16'd0, 0, 1, 0);
      tick(4'h0, 16'd0, 1, 0, 0);

      // 1010 at capture, consumer stalls for 7 cycles
      for (int i = 0; i < 3; i++) tick(4'b1010, 16'd3, 0, 0, 0);
      check("tp3_mon", 64'(report_mon_id), 64'(1));
      s_mon = report_mon_id; s_snap = report_snapshot; s_cyc = report_cycle;
      for (int i = 0; i < 7; i++) begin
         tick(4'($urandom), 16'd3, 1'($urandom), 0, 0);
         check("tp3_hold_valid", 64'(report_valid),    64'(1));
         check("tp3_hold_mon",   64'(report_mon_id),   64'(s_mon));
         check("tp3_hold_snap",  64'(report_snapshot), 64'(s_snap));
         check("tp3_hold_cyc",   64'(report_cycle),    64'(s_cyc));
      end
      tick(4'h0, 16'd3, 0, 1, 0);
      check("tp3_xfer", 64'(report_valid), 64'(0));
      tick(4'h0, 16'd3, 0, 1, 0);
      check("tp3_single", 64'(report_valid), 64'(0));
      tick(4'h0, 16'd3, 1, 1, 0);

      // threshold 0 behaves as 1, ready already high
      c0 = m_cyc;
      tick(4'b0001, 16'd0, 0, 1, 0);
      check("tp4_valid", 64'(report_valid), 64'(1));
      check("tp4_cycle", 64'(report_cycle), 64'(c0));
      tick(4'h0, 16'd0, 0, 1, 0);
      check("tp4_xfer", 64'(report_valid), 64'(0));

      // blocks in HOLD are ignored; clear re-arms
      for (int i = 0; i < 8; i++) tick(4'(i), 16'd1, 0, 0, 0);
      check("tp5_noreport", 64'(report_valid), 64'(0));
      check("tp5_sticky",   64'(deadlock_sticky), 64'(1));
      tick(4'h0, 16'd3, 1, 0, 0);
      check("tp5_cleared",  64'(deadlock_sticky), 64'(0));
      for (int i = 0; i < 3; i++) tick(4'b1000, 16'd3, 0, 0, 0);
      check("tp5_rereport", 64'(report_valid), 64'(1));
      check("tp5_mon",      64'(report_mon_id), 64'(3));

      // reset while a record is pending
      tick(4'h0, 16'd3, 0, 0, 1);
      check("tp6_valid",  64'(report_valid),    64'(0));
      check("tp6_sticky", 64'(deadlock_sticky), 64'(0));
      tick(4'b0100, 16'd1, 0, 0, 0);
      check("tp6_cyc0", 64'(report_cycle), 64'(0));
      tick(4'h0, 16'd1, 0, 1, 0);
      tick(4'h0, 16'd1, 1, 0, 0);

      // randomized traffic with persistent block patterns
      rblk = 4'h0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 99) < 15)
            rblk = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         tick(rblk, 16'($urandom_range(0, 6)),
              1'($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
